// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// CPLL lock / clock-loss detector: counts synchronized ref/fb toggle edges per window (sticky lost flags with GTXE2_CPLL_LOCKDET_STICKY_LOST_EN).
// Latency: toggle to counted edge 3 cycles; outputs registered one cycle after each window-end cycle.
// Backpressure: none; free-running observer with no flow control.
module gtxe2_chnl_cpll_lockdet #(
   parameter int WINDOW       = 256,
   parameter int RATIO        = 1,
   parameter int TOL          = 2,
   parameter int LOCK_WINDOWS = 4,
   parameter int CNT_W        = 16
) (
   input  logic             CPLLLOCKDETCLK,
   input  logic             CPLLRESET,
   input  logic             CPLLLOCKEN,
   input  logic             CPLLPD,
   input  logic             ref_toggle,
   input  logic             fb_toggle,
   output logic             CPLLLOCK,
   output logic             CPLLREFCLKLOST,
   output logic             CPLLFBCLKLOST,
   output logic [CNT_W-1:0] ref_count,
   output logic [CNT_W-1:0] fb_count
);

   localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int GW_W  = $clog2(LOCK_WINDOWS + 1);
   localparam int AW    = CNT_W + 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   state_t             r_state;
   logic [1:0]         r_ref_s;
   logic               r_ref_d;
   logic [1:0]         r_fb_s;
   logic               r_fb_d;
   logic [WIN_W-1:0]   r_win_cnt;
   logic [CNT_W-1:0]   r_ref_cnt;
   logic [CNT_W-1:0]   r_fb_cnt;
   logic [GW_W-1:0]    r_good_cnt;
   logic               r_lock;
   logic               r_ref_lost;
   logic               r_fb_lost;
   logic [CNT_W-1:0]   r_ref_cap;
   logic [CNT_W-1:0]   r_fb_cap;

   logic               w_ref_edge;
   logic               w_fb_edge;
   logic [CNT_W-1:0]   w_ref_next;
   logic [CNT_W-1:0]   w_fb_next;
   logic               w_win_end;
   logic [AW-1:0]      w_exp;
   logic [AW-1:0]      w_fb_ext;
   logic [AW-1:0]      w_diff;
   logic               w_ref_lost;
   logic               w_fb_lost;
   logic               w_good;
   logic [GW_W-1:0]    w_good_inc;
   logic               w_ref_lost_nxt;
   logic               w_fb_lost_nxt;
   logic               w_idle_force;

   // Synchronizers keep running outside MEASURE/LOCKED so no stale level
   // shows up as a false edge when measurement starts.
   always_ff @(posedge CPLLLOCKDETCLK) begin
      if (CPLLRESET) begin
         r_ref_s <= 2'b00;
         r_ref_d <= 1'b0;
         r_fb_s  <= 2'b00;
         r_fb_d  <= 1'b0;
      end else begin
         r_ref_s <= {r_ref_s[0], ref_toggle};
         r_ref_d <= r_ref_s[1];
         r_fb_s  <= {r_fb_s[0], fb_toggle};
         r_fb_d  <= r_fb_s[1];
      end
   end

   assign w_ref_edge = r_ref_s[1] ^ r_ref_d;
   assign w_fb_edge  = r_fb_s[1] ^ r_fb_d;

   assign w_ref_next = (&r_ref_cnt) ? r_ref_cnt : r_ref_cnt + {{(CNT_W-1){1'b0}}, w_ref_edge};
   assign w_fb_next  = (&r_fb_cnt)  ? r_fb_cnt  : r_fb_cnt  + {{(CNT_W-1){1'b0}}, w_fb_edge};

   assign w_win_end  = (r_win_cnt == WIN_W'(WINDOW - 1));

   assign w_exp      = AW'(w_ref_next) * AW'(RATIO);
   assign w_fb_ext   = AW'(w_fb_next);
   assign w_diff     = (w_fb_ext >= w_exp) ? (w_fb_ext - w_exp) : (w_exp - w_fb_ext);
   assign w_ref_lost = (w_ref_next == '0);
   assign w_fb_lost  = (w_fb_next == '0);
   assign w_good     = !w_ref_lost && !w_fb_lost && (w_diff <= AW'(TOL));
   assign w_good_inc = (r_good_cnt >= GW_W'(LOCK_WINDOWS)) ? r_good_cnt : r_good_cnt + GW_W'(1);

`ifdef GTXE2_CPLL_LOCKDET_STICKY_LOST_EN
   assign w_ref_lost_nxt = r_ref_lost | w_ref_lost;
   assign w_fb_lost_nxt  = r_fb_lost  | w_fb_lost;
`else
   assign w_ref_lost_nxt = w_ref_lost;
   assign w_fb_lost_nxt  = w_fb_lost;
`endif

   // Disable/power-down takes priority over a coincident window end.
   assign w_idle_force = CPLLRESET || !CPLLLOCKEN || CPLLPD;

   always_ff @(posedge CPLLLOCKDETCLK) begin
      if (w_idle_force) begin
         r_state    <= S_IDLE;
         r_win_cnt  <= '0;
         r_ref_cnt  <= '0;
         r_fb_cnt   <= '0;
         r_good_cnt <= '0;
         r_lock     <= 1'b0;
         r_ref_lost <= 1'b0;
         r_fb_lost  <= 1'b0;
         r_ref_cap  <= '0;
         r_fb_cap   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state    <= S_MEASURE;
               r_win_cnt  <= '0;
               r_ref_cnt  <= '0;
               r_fb_cnt   <= '0;
               r_good_cnt <= '0;
               r_lock     <= 1'b0;
            end
            default: begin
               if (w_win_end) begin
                  r_win_cnt  <= '0;
                  r_ref_cnt  <= '0;
                  r_fb_cnt   <= '0;
                  r_ref_cap  <= w_ref_next;
                  r_fb_cap   <= w_fb_next;
                  r_ref_lost <= w_ref_lost_nxt;
                  r_fb_lost  <= w_fb_lost_nxt;
                  if (w_good) begin
                     r_good_cnt <= w_good_inc;
                     if (w_good_inc == GW_W'(LOCK_WINDOWS)) begin
                        r_state <= S_LOCKED;
                        r_lock  <= 1'b1;
                     end else begin
                        r_state <= S_MEASURE;
                        r_lock  <= 1'b0;
                     end
                  end else begin
                     r_good_cnt <= '0;
                     r_state    <= S_MEASURE;
                     r_lock     <= 1'b0;
                  end
               end else begin
                  r_win_cnt <= r_win_cnt + WIN_W'(1);
                  r_ref_cnt <= w_ref_next;
                  r_fb_cnt  <= w_fb_next;
               end
            end
         endcase
      end
   end

   assign CPLLLOCK       = r_lock;
   assign CPLLREFCLKLOST = r_ref_lost;
   assign CPLLFBCLKLOST  = r_fb_lost;
   assign ref_count      = r_ref_cap;
   assign fb_count       = r_fb_cap;

endmodule
